// File: rtl/dmem_responder.sv
// dmem_responder: memory-side responder for the MEM-stage data access port.
// Accepts one load/store at a time, waits WAIT_CYCLES wait states and then
// performs the access on an internal big-endian byte array. Reports
// misaligned or illegal-size accesses through rsp_err.
//
// Optional feature: define DMEM_ERR_STICKY_EN to turn err_sticky into a flag
// that is set by any error response and cleared only by reset. Without that
// macro, err_sticky is a constant 0.
//
// Handshake: a request transfers on a rising clk edge where req_valid and
// req_ready are both 1. req_ready is 1 only in IDLE, so at most one request
// is outstanding. rsp_valid is a one-cycle pulse and has no back-pressure.
// rsp_rdata and rsp_err are only meaningful while rsp_valid is 1.
module dmem_responder #(
    parameter int ADDR_W      = 9,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_rw,
    input  logic [1:0]        req_size,
    input  logic              req_se,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              busy,
    output logic              err_sticky
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);
    localparam bit         ZERO_WAIT = (WAIT_CYCLES == 0);
    localparam int         DEPTH     = 1 << ADDR_W;

    state_t            state;
    logic [3:0]        cnt;

    // Holding registers for the accepted request.
    logic              h_rw;
    logic [1:0]        h_size;
    logic              h_se;
    logic [ADDR_W-1:0] h_addr;
    logic [31:0]       h_wdata;

    // Request actually used for the access on the RESP-entry edge. With zero
    // wait states that edge is the acceptance edge, so the live inputs are used.
    logic              a_rw;
    logic [1:0]        a_size;
    logic              a_se;
    logic [ADDR_W-1:0] a_addr;
    logic [31:0]       a_wdata;
    logic [ADDR_W-1:0] a_addr1;
    logic [ADDR_W-1:0] a_addr2;
    logic [ADDR_W-1:0] a_addr3;

    logic              acc_go;
    logic              a_err;
    logic              wr_en;
    logic [7:0]        b0;
    logic [7:0]        b1;
    logic [7:0]        b2;
    logic [7:0]        b3;
    logic [31:0]       rsp_data_c;

    logic [7:0]        mem [0:DEPTH-1];

    // Select held or live request fields for the access.
    always_comb begin
        a_rw    = h_rw;
        a_size  = h_size;
        a_se    = h_se;
        a_addr  = h_addr;
        a_wdata = h_wdata;
        if (state == ST_IDLE) begin
            a_rw    = req_rw;
            a_size  = req_size;
            a_se    = req_se;
            a_addr  = req_addr;
            a_wdata = req_wdata;
        end
    end

    assign a_addr1 = a_addr + ADDR_W'(1);
    assign a_addr2 = a_addr + ADDR_W'(2);
    assign a_addr3 = a_addr + ADDR_W'(3);

    // Decide whether this edge is the RESP-entry (access) edge. Reset blocks it
    // so a zero-wait request seen during reset cannot write.
    always_comb begin
        acc_go = 1'b0;
        if (!reset) begin
            if (state == ST_IDLE && req_valid && ZERO_WAIT)
                acc_go = 1'b1;
            else if (state == ST_WAIT && cnt == 4'd1)
                acc_go = 1'b1;
        end
    end

    // Alignment / size legality of the access.
    always_comb begin
        case (a_size)
            2'b00:   a_err = 1'b0;
            2'b01:   a_err = a_addr[0];
            2'b10:   a_err = (a_addr[1:0] != 2'b00);
            default: a_err = 1'b1;
        endcase
    end

    assign wr_en = acc_go && a_rw && !a_err;

    assign b0 = mem[a_addr];
    assign b1 = mem[a_addr1];
    assign b2 = mem[a_addr2];
    assign b3 = mem[a_addr3];

    // Form the response data: big-endian assembly with optional sign extension.
    always_comb begin
        rsp_data_c = 32'd0;
        if (!a_rw && !a_err) begin
            case (a_size)
                2'b00:   rsp_data_c = {{24{a_se & b0[7]}}, b0};
                2'b01:   rsp_data_c = {{16{a_se & b0[7]}}, b0, b1};
                2'b10:   rsp_data_c = {b0, b1, b2, b3};
                default: rsp_data_c = 32'd0;
            endcase
        end
    end

    // Byte array write port; stores land only on the RESP-entry edge.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            case (a_size)
                2'b00: mem[a_addr] <= a_wdata[7:0];
                2'b01: begin
                    mem[a_addr]  <= a_wdata[15:8];
                    mem[a_addr1] <= a_wdata[7:0];
                end
                2'b10: begin
                    mem[a_addr]  <= a_wdata[31:24];
                    mem[a_addr1] <= a_wdata[23:16];
                    mem[a_addr2] <= a_wdata[15:8];
                    mem[a_addr3] <= a_wdata[7:0];
                end
                default: ;
            endcase
        end
    end

    // Control FSM with registered handshake, status and response outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            cnt       <= 4'd0;
            h_rw      <= 1'b0;
            h_size    <= 2'b00;
            h_se      <= 1'b0;
            h_addr    <= '0;
            h_wdata   <= 32'd0;
            req_ready <= 1'b1;
            busy      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    rsp_valid <= 1'b0;
                    if (req_valid) begin
                        h_rw      <= req_rw;
                        h_size    <= req_size;
                        h_se      <= req_se;
                        h_addr    <= req_addr;
                        h_wdata   <= req_wdata;
                        cnt       <= WAIT_INIT;
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        if (ZERO_WAIT) begin
                            state     <= ST_RESP;
                            rsp_valid <= 1'b1;
                            rsp_rdata <= rsp_data_c;
                            rsp_err   <= a_err;
                        end else begin
                            state <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state     <= ST_RESP;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= rsp_data_c;
                        rsp_err   <= a_err;
                    end
                end
                ST_RESP: begin
                    state     <= ST_IDLE;
                    rsp_valid <= 1'b0;
                    rsp_rdata <= 32'd0;
                    rsp_err   <= 1'b0;
                    busy      <= 1'b0;
                    req_ready <= 1'b1;
                end
                default: begin
                    state     <= ST_IDLE;
                    rsp_valid <= 1'b0;
                    busy      <= 1'b0;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

`ifdef DMEM_ERR_STICKY_EN
    // Sticky error status: set by any error response, cleared only by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            err_sticky <= 1'b0;
        else if (acc_go && a_err)
            err_sticky <= 1'b1;
    end
`else
    assign err_sticky = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Testbench for dmem_responder: a WAIT_CYCLES=2 instance for the main
// function and a WAIT_CYCLES=0 instance for the zero-wait path.
module tb_dmem_responder;

  localparam int AW = 9;

`ifdef DMEM_ERR_STICKY_EN
  localparam logic STICKY_ON = 1'b1;
`else
  localparam logic STICKY_ON = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT (WAIT_CYCLES = 2) ----------------
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_rw = 1'b0;
  logic [1:0]    req_size = 2'b00;
  logic          req_se = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [31:0]   req_wdata = 32'd0;
  logic          rsp_valid;
  logic [31:0]   rsp_rdata;
  logic          rsp_err;
  logic          busy;
  logic          err_sticky;

  dmem_responder #(.ADDR_W(AW), .WAIT_CYCLES(2)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_rw(req_rw), .req_size(req_size), .req_se(req_se),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .busy(busy), .err_sticky(err_sticky)
  );

  // ---------------- DUT (WAIT_CYCLES = 0) ----------------
  logic          z_req_valid = 1'b0;
  logic          z_req_ready;
  logic          z_req_rw = 1'b0;
  logic [1:0]    z_req_size = 2'b00;
  logic          z_req_se = 1'b0;
  logic [AW-1:0] z_req_addr = '0;
  logic [31:0]   z_req_wdata = 32'd0;
  logic          z_rsp_valid;
  logic [31:0]   z_rsp_rdata;
  logic          z_rsp_err;
  logic          z_busy;
  logic          z_err_sticky;

  dmem_responder #(.ADDR_W(AW), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset),
    .req_valid(z_req_valid), .req_ready(z_req_ready),
    .req_rw(z_req_rw), .req_size(z_req_size), .req_se(z_req_se),
    .req_addr(z_req_addr), .req_wdata(z_req_wdata),
    .rsp_valid(z_rsp_valid), .rsp_rdata(z_rsp_rdata), .rsp_err(z_rsp_err),
    .busy(z_busy), .err_sticky(z_err_sticky)
  );

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- driver ----------------
  // Entered at a negedge with the selected DUT idle; returns at the negedge
  // after the response cycle (the DUT is idle again there).
  task automatic txn(input bit z, input string tag, input logic rw, input logic [1:0] size,
                     input logic se, input logic [AW-1:0] addr, input logic [31:0] wdata,
                     input logic [31:0] exp_rdata, input logic exp_err);
    int n;
    int exp_lat;
    bit busy_ok;
    bit got;
    logic [31:0] exp_d;
    exp_q.push_back(exp_rdata);
    exp_lat = z ? 1 : 3;
    if (z) begin
      check_eq({tag, "_ready"}, {31'd0, z_req_ready}, 32'd1);
      z_req_valid = 1'b1; z_req_rw = rw; z_req_size = size; z_req_se = se;
      z_req_addr = addr; z_req_wdata = wdata;
    end else begin
      check_eq({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
      req_valid = 1'b1; req_rw = rw; req_size = size; req_se = se;
      req_addr = addr; req_wdata = wdata;
    end
    n = 0;
    busy_ok = 1'b1;
    got = 1'b0;
    while (n < 20 && !got) begin
      @(negedge clk);
      n++;
      req_valid = 1'b0;
      z_req_valid = 1'b0;
      if (z) begin
        if (!z_busy) busy_ok = 1'b0;
        got = z_rsp_valid;
      end else begin
        if (!busy) busy_ok = 1'b0;
        got = rsp_valid;
      end
    end
    exp_d = exp_q.pop_front();
    if (!got) begin
      check_eq({tag, "_timeout"}, 32'd0, 32'd1);
    end else begin
      check_eq({tag, "_latency"}, n, exp_lat);
      check_eq({tag, "_busy"}, {31'd0, busy_ok}, 32'd1);
      check_eq({tag, "_rdata"}, z ? z_rsp_rdata : rsp_rdata, exp_d);
      check_eq({tag, "_err"}, {31'd0, z ? z_rsp_err : rsp_err}, {31'd0, exp_err});
      check_eq({tag, "_ready_low"}, {31'd0, z ? z_req_ready : req_ready}, 32'd0);
      @(negedge clk);
      check_eq({tag, "_pulse"}, {31'd0, z ? z_rsp_valid : rsp_valid}, 32'd0);
      check_eq({tag, "_idle"}, {30'd0, z ? z_busy : busy, z ? z_req_ready : req_ready}, 32'd1);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int seen;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("rst_ready", {31'd0, req_ready}, 32'd1);
    check_eq("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check_eq("rst_rdata", rsp_rdata, 32'd0);
    check_eq("rst_err", {31'd0, rsp_err}, 32'd0);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_sticky", {31'd0, err_sticky}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Word store and big-endian reads back.
    txn(0, "sw_010", 1, 2'b10, 0, 9'h010, 32'h11223344, 32'h0, 0);
    txn(0, "lbu_010", 0, 2'b00, 0, 9'h010, 32'h0, 32'h00000011, 0);
    txn(0, "lbu_013", 0, 2'b00, 0, 9'h013, 32'h0, 32'h00000044, 0);
    txn(0, "lhu_012", 0, 2'b01, 0, 9'h012, 32'h0, 32'h00003344, 0);
    txn(0, "lw_010", 0, 2'b10, 0, 9'h010, 32'h0, 32'h11223344, 0);
    txn(0, "lb_011", 0, 2'b00, 1, 9'h011, 32'h0, 32'h00000022, 0);

    // Sign extension.
    txn(0, "sb_020", 1, 2'b00, 0, 9'h020, 32'hAAAAAA80, 32'h0, 0);
    txn(0, "lb_020", 0, 2'b00, 1, 9'h020, 32'h0, 32'hFFFFFF80, 0);
    txn(0, "lbu_020", 0, 2'b00, 0, 9'h020, 32'h0, 32'h00000080, 0);
    txn(0, "sh_022", 1, 2'b01, 0, 9'h022, 32'h12348001, 32'h0, 0);
    txn(0, "lh_022", 0, 2'b01, 1, 9'h022, 32'h0, 32'hFFFF8001, 0);
    txn(0, "lhu_022", 0, 2'b01, 0, 9'h022, 32'h0, 32'h00008001, 0);
    txn(0, "lbu_023", 0, 2'b00, 0, 9'h023, 32'h0, 32'h00000001, 0);
    txn(0, "lb_022", 0, 2'b00, 1, 9'h022, 32'h0, 32'hFFFFFF80, 0);

    // Misalignment and illegal size.
    check_eq("sticky_before_err", {31'd0, err_sticky}, 32'd0);
    txn(0, "sw_011_mis", 1, 2'b10, 0, 9'h011, 32'hDEADBEEF, 32'h0, 1);
    check_eq("sticky_after_err", {31'd0, err_sticky}, {31'd0, STICKY_ON});
    txn(0, "lw_010_after", 0, 2'b10, 0, 9'h010, 32'h0, 32'h11223344, 0);
    txn(0, "lh_013_mis", 0, 2'b01, 1, 9'h013, 32'h0, 32'h0, 1);
    txn(0, "lw_012_mis", 0, 2'b10, 0, 9'h012, 32'h0, 32'h0, 1);
    txn(0, "size11", 0, 2'b11, 0, 9'h010, 32'h0, 32'h0, 1);
    txn(0, "sw_014", 1, 2'b10, 0, 9'h014, 32'hA5A5A5A5, 32'h0, 0);
    check_eq("sticky_holds", {31'd0, err_sticky}, {31'd0, STICKY_ON});
    txn(0, "lw_014", 0, 2'b10, 0, 9'h014, 32'h0, 32'hA5A5A5A5, 0);

    // Reset while in WAIT: request discarded, no write, no response.
    req_valid = 1'b1; req_rw = 1'b1; req_size = 2'b10; req_se = 1'b0;
    req_addr = 9'h010; req_wdata = 32'h55667788;
    @(negedge clk);
    req_valid = 1'b0;
    check_eq("mid_busy_before", {31'd0, busy}, 32'd1);
    #2 reset = 1'b1;
    #1;
    check_eq("mid_ready", {31'd0, req_ready}, 32'd1);
    check_eq("mid_busy", {31'd0, busy}, 32'd0);
    check_eq("mid_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check_eq("mid_sticky", {31'd0, err_sticky}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    check_eq("mid_no_rsp", seen, 0);
    txn(0, "lw_010_post_rst", 0, 2'b10, 0, 9'h010, 32'h0, 32'h11223344, 0);

    // Zero wait states: response the cycle after acceptance, back-to-back next.
    txn(1, "z_sw_040", 1, 2'b10, 0, 9'h040, 32'hCAFEF00D, 32'h0, 0);
    txn(1, "z_lw_040", 0, 2'b10, 0, 9'h040, 32'h0, 32'hCAFEF00D, 0);
    txn(1, "z_lhu_042", 0, 2'b01, 0, 9'h042, 32'h0, 32'h0000F00D, 0);
    txn(1, "z_lb_040", 0, 2'b00, 1, 9'h040, 32'h0, 32'hFFFFFFCA, 0);
    txn(1, "z_lw_041_mis", 0, 2'b10, 0, 9'h041, 32'h0, 32'h0, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global time limit so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "time limit");
  end

endmodule
